// File: rtl/common.sv
`default_nettype none
// ============================================================================
//  Module      : common (package)
//  Description : Shared RV32I definitions for the instruction encoder.
//                - opcode_t : major opcode encodings
//                - fmt_t    : instruction format implied by an opcode
//                - immediate range limits used by the range check
//                - fmt_of() : opcode -> format classification
//  Revision    : 1.0  initial release
// ============================================================================
package common;

  typedef enum logic [6:0] {
    LD     = 7'b0000011,
    REGIMM = 7'b0010011,
    AUIPC  = 7'b0010111,
    STR    = 7'b0100011,
    LUI    = 7'b0110111,
    BR     = 7'b1100011,
    JALR   = 7'b1100111,
    JAL    = 7'b1101111
  } opcode_t;

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_J = 3'd3,
    FMT_U = 3'd4,
    FMT_R = 3'd5
  } fmt_t;

  // Representable signed immediate ranges per format
  localparam int c_imm_i_min = -2048;
  localparam int c_imm_i_max = 2047;
  localparam int c_imm_b_min = -4096;
  localparam int c_imm_b_max = 4094;
  localparam int c_imm_j_min = -1048576;
  localparam int c_imm_j_max = 1048574;

  // Anything not listed is packed as an R-type word
  function automatic fmt_t fmt_of(input logic [6:0] op);
    case (op)
      REGIMM, LD, JALR: fmt_of = FMT_I;
      STR:              fmt_of = FMT_S;
      BR:               fmt_of = FMT_B;
      JAL:              fmt_of = FMT_J;
      LUI, AUIPC:       fmt_of = FMT_U;
      default:          fmt_of = FMT_R;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : imm_encoder
//  Description : Combinational immediate scatter. Places the opcode and the
//                immediate bits of the opcode's format into a 32-bit word;
//                register and funct fields are left zero for the caller.
//                With IMM_RANGE_CHECK_EN defined, also flags immediates that
//                the format cannot represent; otherwise range_err is 0.
//  Ports       : opcode    [6:0]  in  : major opcode
//                imm       [31:0] in  : sign-extended immediate
//                word      [31:0] out : opcode + placed immediate bits
//                range_err        out : immediate not representable
//  Revision    : 1.0  initial release
// ============================================================================
module imm_encoder
  import common::*;
(
  input  logic [6:0]  opcode,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_err
);

  fmt_t w_fmt;
  assign w_fmt = fmt_of(opcode);

  always_comb begin
    word = {25'b0, opcode};
    case (w_fmt)
      FMT_I:   word = {imm[11:0], 13'b0, opcode};
      FMT_S:   word = {imm[11:5], 13'b0, imm[4:0], opcode};
      FMT_B:   word = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], opcode};
      FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], 5'b0, opcode};
      FMT_U:   word = {imm[31:12], 5'b0, opcode};
      default: word = {25'b0, opcode};
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic signed [31:0] w_simm;
  assign w_simm = imm;

  always_comb begin
    range_err = 1'b0;
    case (w_fmt)
      FMT_I, FMT_S: range_err = (w_simm < c_imm_i_min) || (w_simm > c_imm_i_max);
      FMT_B:        range_err = (w_simm < c_imm_b_min) || (w_simm > c_imm_b_max) || imm[0];
      FMT_J:        range_err = (w_simm < c_imm_j_min) || (w_simm > c_imm_j_max) || imm[0];
      FMT_U:        range_err = (imm[11:0] != 12'd0);
      default:      range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Pipelined RV32I instruction encoder. Packs decoded fields
//                into a 32-bit word through one output register stage with
//                valid/ready on both sides, and assigns sequential byte
//                addresses starting at BASE_ADDR.
//                Optional feature macro: IMM_RANGE_CHECK_EN enables out_err
//                and the saturating err_cnt; without it both read 0.
//  Ports       : clk, rst_n (sync, active-low), clr (sync flush)
//                in_valid/in_ready, in_opcode, in_rd, in_rs1, in_rs2,
//                in_funct3, in_funct7, in_imm          : input fields
//                out_valid/out_ready, out_instr, out_addr, out_err : output
//                err_cnt                                : error count
//  Revision    : 1.0  initial release
// ============================================================================
module instr_encoder
  import common::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  localparam logic [ADDR_W-1:0] c_base = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_step = ADDR_W'(4);

  logic [31:0]       w_imm_word;
  logic              w_range_err;
  logic [31:0]       w_fields;
  fmt_t              w_fmt;
  logic              w_accept;
  logic              w_hs;

  logic              r_valid;
  logic [31:0]       r_instr;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;

  imm_encoder u_imm_encoder (
    .opcode    (in_opcode),
    .imm       (in_imm),
    .word      (w_imm_word),
    .range_err (w_range_err)
  );

  // Register/funct fields only enter the word where the format has them,
  // so stray values on unused inputs never leak into the encoding.
  assign w_fmt = fmt_of(in_opcode);

  always_comb begin
    w_fields = '0;
    if (w_fmt inside {FMT_I, FMT_J, FMT_U, FMT_R}) w_fields[11:7]  = in_rd;
    if (w_fmt inside {FMT_I, FMT_S, FMT_B, FMT_R}) w_fields[14:12] = in_funct3;
    if (w_fmt inside {FMT_I, FMT_S, FMT_B, FMT_R}) w_fields[19:15] = in_rs1;
    if (w_fmt inside {FMT_S, FMT_B, FMT_R})        w_fields[24:20] = in_rs2;
    if (w_fmt == FMT_R)                            w_fields[31:25] = in_funct7;
  end

  assign in_ready = !clr && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_hs     = r_valid && out_ready;

  // clr dominates a coincident handshake: the address reloads, no +4.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_err   <= 1'b0;
      r_addr  <= c_base;
    end else if (clr) begin
      r_valid <= 1'b0;
      r_addr  <= c_base;
    end else begin
      if (w_hs) begin
        r_addr <= r_addr + c_step;
      end
      if (w_accept) begin
        r_valid <= 1'b1;
        r_instr <= w_imm_word | w_fields;
        r_err   <= w_range_err;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_instr = r_instr;
  assign out_addr  = r_addr;
  // r_err is constant 0 when the range check is compiled out
  assign out_err   = r_err;

`ifdef IMM_RANGE_CHECK_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (!clr && w_hs && r_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Self-checking bench for instr_encoder (BASE_ADDR = 0).
//                Table vectors with known encodings, hand-written stall /
//                clear / reset sequences, then a randomized stream checked
//                against a behavioural model built from the format rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_encoder;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm, out_instr, out_addr;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(32'h0), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (format rules, numeric opcodes) -------
  function automatic logic [31:0] ref_word(input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    case (op)
      7'h13, 7'h03, 7'h67: return {imm[11:0], rs1, f3, rd, op};
      7'h23: return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      7'h63: return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      7'h6F: return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      7'h37, 7'h17: return {imm[31:12], rd, op};
      default: return {f7, rs2, rs1, f3, rd, op};
    endcase
  endfunction

  function automatic bit ref_err(input logic [6:0] op, input logic [31:0] imm);
    longint s;
    s = longint'($signed(imm));
    if (!ERR_ON) return 1'b0;
    case (op)
      7'h13, 7'h03, 7'h67, 7'h23: return (s < -2048) || (s > 2047);
      7'h63: return (s < -4096) || (s > 4094) || (s % 2 != 0);
      7'h6F: return (s < -(longint'(1) << 20)) || (s > (longint'(1) << 20) - 2) || (s % 2 != 0);
      7'h37, 7'h17: return (imm % 4096) != 0;
      default: return 1'b0;
    endcase
  endfunction

  bit          m_valid = 1'b0;
  bit          m_err   = 1'b0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_addr  = '0;
  int          m_cnt   = 0;

  // One clock: check in_ready against the model, advance the model with the
  // currently driven inputs, then compare registered outputs after the edge.
  task automatic step();
    bit exp_rdy, hs, acc, ne;
    logic [31:0] nw;
    #1;
    exp_rdy = !clr && (!m_valid || out_ready);
    check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    hs  = m_valid && out_ready;
    acc = in_valid && exp_rdy;
    nw  = ref_word(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
    ne  = ref_err(in_opcode, in_imm);
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_instr = '0; m_err = 0; m_addr = '0; m_cnt = 0;
    end else if (clr) begin
      m_valid = 0; m_addr = '0;
    end else begin
      if (hs) begin
        m_addr = m_addr + 32'd4;
        if (m_err && m_cnt < 255) m_cnt++;
      end
      if (acc) begin
        m_valid = 1; m_instr = nw; m_err = ne;
      end else if (hs) begin
        m_valid = 0;
      end
    end
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("out_addr", out_addr, m_addr);
    check("err_cnt", {24'b0, err_cnt}, m_cnt);
    if (m_valid) begin
      check("out_instr", out_instr, m_instr);
      check("out_err", {31'b0, out_err}, {31'b0, m_err});
    end
  endtask

  // ---------------- table vectors -----------------------------------------
  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] instr;
    bit          err;
  } vec_t;

  vec_t vecs[10];

  task automatic drive(input vec_t v);
    in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
  endtask

  task automatic drive_rand();
    logic [6:0] ops[9] = '{7'h13, 7'h23, 7'h03, 7'h63, 7'h6F, 7'h67, 7'h17, 7'h37, 7'h33};
    int k;
    k = $urandom_range(0, 9);
    in_opcode = (k == 9) ? 7'($urandom) : ops[k];
    in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
    in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
    case ($urandom_range(0, 2))
      0: in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      1: in_imm = {$urandom} & 32'hFFFF_F000;
      default: in_imm = $urandom;
    endcase
  endtask

  initial begin
    //              op     rd     rs1    rs2    f3    f7     imm            instr          err
    vecs[0] = '{7'h37, 5'd5,  5'd31, 5'd9,  3'd7, 7'h7F, 32'h1234_5000, 32'h1234_52B7, 1'b0};
    vecs[1] = '{7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0};
    vecs[2] = '{7'h63, 5'd17, 5'd1,  5'd2,  3'd0, 7'h55, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0};
    vecs[3] = '{7'h6F, 5'd1,  5'd3,  5'd4,  3'd5, 7'h11, 32'h0000_0008, 32'h0080_00EF, 1'b0};
    vecs[4] = '{7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0000_0800, 32'h8000_0093, 1'b1};
    vecs[5] = '{7'h23, 5'd7,  5'd1,  5'd2,  3'd2, 7'h00, 32'h0000_0008, 32'h0020_A423, 1'b0};
    vecs[6] = '{7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0};
    vecs[7] = '{7'h03, 5'd5,  5'd2,  5'd30, 3'd2, 7'h00, 32'hFFFF_FFFC, 32'hFFC1_2283, 1'b0};
    vecs[8] = '{7'h67, 5'd0,  5'd1,  5'd0,  3'd0, 7'h00, 32'h0000_0000, 32'h0000_8067, 1'b0};
    vecs[9] = '{7'h63, 5'd0,  5'd1,  5'd2,  3'd0, 7'h00, 32'h0000_0003, 32'h0020_8163, 1'b1};

    rst_n = 0; clr = 0; in_valid = 0; out_ready = 1;
    drive(vecs[0]);
    @(posedge clk);
    step(); step();
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_addr", out_addr, 32'd0);
    check("rst_cnt", {24'b0, err_cnt}, 32'd0);
    rst_n = 1;

    // Back-to-back table stream: word i lands at address 4*i
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i]); in_valid = 1;
      step();
      check("tbl_instr", out_instr, vecs[i].instr);
      check("tbl_addr", out_addr, 32'(4 * i));
      check("tbl_err", {31'b0, out_err}, {31'b0, ERR_ON & vecs[i].err});
    end
    in_valid = 0; step();
    check("tbl_cnt", {24'b0, err_cnt}, ERR_ON ? 32'd2 : 32'd0);
    clr = 1; step(); clr = 0;

    // Stall: word held for 3 cycles, then address advances once
    drive(vecs[0]); in_valid = 1; step();
    out_ready = 0; drive(vecs[1]);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_instr", out_instr, 32'h1234_52B7);
      check("stall_addr", out_addr, 32'd0);
    end
    out_ready = 1; in_valid = 0; step();
    check("stall_release_addr", out_addr, 32'd4);

    // Clear after a 3-word stream, with in_valid still high
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin drive(vecs[i + 5]); step(); end
    clr = 1; drive(vecs[8]); step();
    check("clr_valid", {31'b0, out_valid}, 32'd0);
    check("clr_addr", out_addr, 32'd0);
    clr = 0; in_valid = 0; step();
    check("clr_no_accept", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of a stall discards the held word
    drive(vecs[4]); in_valid = 1; step();
    out_ready = 0; in_valid = 0; step();
    rst_n = 0; step();
    check("rst2_valid", {31'b0, out_valid}, 32'd0);
    check("rst2_instr", out_instr, 32'd0);
    check("rst2_err", {31'b0, out_err}, 32'd0);
    check("rst2_addr", out_addr, 32'd0);
    check("rst2_cnt", {24'b0, err_cnt}, 32'd0);
    rst_n = 1; out_ready = 1;

    // Randomized stream against the model
    for (int i = 0; i < 600; i++) begin
      drive_rand();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      clr       = ($urandom_range(0, 39) == 0);
      step();
    end
    clr = 0; in_valid = 0; out_ready = 1; step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RV32I instruction encoder: the inverse of the immediate decoder. It takes decoded fields (opcode, registers, funct fields, full 32-bit immediate) and packs them into a 32-bit instruction word, scattering the immediate bits per format. It sits between the test/boot loader and instruction memory. It has valid/ready on both sides, assigns sequential memory addresses, and optionally flags immediates that cannot be represented in the target format.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: first write address after reset or clear.
- `ADDR_W`, default 32: width of the address counter.
- `clk` input 1: clock.
- `rst_n` input 1: reset, **synchronous, active-low**.
- `clr` input 1: synchronous flush. Drops the pending output and reloads the address.
- `in_valid` input 1: input fields valid.
- `in_ready` output 1: encoder can accept.
- `in_opcode` input 7: `opcode_t` value.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register fields.
- `in_funct3` input 3, `in_funct7` input 7: function fields.
- `in_imm` input 32: full sign-extended immediate, as produced by the decoder.
- `out_valid` output 1: encoded word valid.
- `out_ready` input 1: consumer accepts.
- `out_instr` output 32: encoded word.
- `out_addr` output ADDR_W: byte address for `out_instr`.
- `out_err` output 1: immediate not representable. Always 0 without the macro.
- `err_cnt` output 8: saturating error count. Always 0 without the macro.

## Operation
- Bits [6:0] of the word = opcode. Placement by opcode:
  - REGIMM, LD, JALR: `{imm[11:0], rs1, funct3, rd, op}`.
  - STR: `{imm[11:5], rs2, rs1, funct3, imm[4:0], op}`.
  - BR: `{imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}`.
  - JAL: `{imm[20], imm[10:1], imm[11], imm[19:12], rd, op}`.
  - LUI, AUIPC: `{imm[31:12], rd, op}`.
  - Any other opcode: R-type `{funct7, rs2, rs1, funct3, rd, op}`; `in_imm` is ignored.
- Fields an opcode does not use are ignored and do not affect the word.
- Address counter:
  - `out_addr` starts at BASE_ADDR.
  - Increments by 4 on each output handshake (`out_valid && out_ready`).
  - Wraps modulo 2^ADDR_W.
- Range check (macro on). `out_err` = 1 when decoding the produced word would not return `in_imm`:
  - I/S types: imm outside [-2048, 2047].
  - BR: imm outside [-4096, 4094] or imm[0] ≠ 0.
  - JAL: imm outside [-2^20, 2^20-2] or imm[0] ≠ 0.
  - U types: imm[11:0] ≠ 0.
  - R-type: never.
- An erroring word is still emitted, with truncated bits.
- `err_cnt` increments on each output handshake carrying `out_err` = 1 and saturates at 255.

## Timing
- Single output register stage. Latency is 1 cycle from input handshake to `out_valid`.
- `in_ready = !clr && (!out_valid || out_ready)`. Full throughput of one word per cycle when `out_ready` is held high.
- While `out_valid` = 1 and `out_ready` = 0, `out_instr`, `out_addr` and `out_err` are held stable.
- On reset (`rst_n` = 0 at a clock edge):
  - `out_valid` = 0, `out_instr` = 0, `out_err` = 0.
  - `out_addr` = BASE_ADDR, `err_cnt` = 0.
  - Reset mid-transfer discards the held word.
- On `clr` = 1:
  - Next cycle `out_valid` = 0 and `out_addr` = BASE_ADDR; `err_cnt` is unchanged.
  - Input is not accepted in that cycle.
  - If `clr` coincides with an output handshake, the address still reloads to BASE_ADDR. It does not take +4.
- Simultaneous output handshake and new input: the new word loads and `out_valid` stays 1. The address advances by exactly 4 per handshake.

## Configuration
- `IMM_RANGE_CHECK_EN` defined: range-check logic, `out_err` and the `err_cnt` counter are compiled in.
- Not defined: the check logic is removed, and `out_err` and `err_cnt` are tied to 0. Encoding and timing are identical in both builds.

## Structure
- `opcode_t` and its encodings (REGIMM, STR, LD, BR, JAL, JALR, AUIPC, LUI) come from package `common`.
- The immediate range limits are added to `common` as constants.
- One combinational sub-module, `imm_encoder`: opcode + imm → the 32-bit word with immediate bits and opcode placed, plus the range-error flag.
- The top level holds the handshake register, address counter and error counter.

## Test plan
- Each check is for BASE_ADDR = 0 with `out_ready` held high unless stated.
- LUI, rd=5, imm=32'h12345000 → `out_instr` = 32'h123452B7, `out_addr` = 0, `out_err` = 0.
- REGIMM, rd=1, rs1=0, funct3=0, imm=-1 → 32'hFFF00093. Next word at `out_addr` = 4.
- BR, rs1=1, rs2=2, funct3=0, imm=-4 → 32'hFE208EE3. JAL, rd=1, imm=8 → 32'h008000EF.
- REGIMM, imm=2048 with macro on → `out_err` = 1, word emitted, `err_cnt` = 1. Same stimulus with macro off → `out_err` = 0.
- Word accepted, then `out_ready` low for 3 cycles → `out_instr` and `out_addr` stable, `in_ready` = 0, address advances once when `out_ready` rises.
- Reset and clear:
  - Stream 3 words, then assert `clr` with `in_valid` = 1 → no input accepted, `out_valid` = 0, `out_addr` returns to 0.
  - Assert `rst_n` low mid-stall → all outputs at their reset values.
